rx_word_assembler: RTL

Sits directly downstream of the UART receiver. It consumes the receiver's one-cycle done pulse and data byte, and packs NB_BYTES consecutive bytes little-endian into one word. The word is presented to the debug unit over a valid/ready handshake. Provides one word of buffering behind the output register, a sticky overrun flag, and an inter-byte timeout that discards stale partial words.

---
 rtl/rx_word_assembler.sv | 101 ++++++++++
 1 files changed

// File: rtl/rx_word_assembler.sv
// Packs NB_BYTES received UART bytes little-endian into one word, presented over valid/ready.
// One word of buffering behind the output register, sticky overrun, inter-byte timeout.
module rx_word_assembler #(
  parameter int unsigned NB_DATA       = 8,
  parameter int unsigned NB_BYTES      = 4,
  parameter int unsigned TIMEOUT_TICKS = 320
) (
  input  logic                             i_clock,
  input  logic                             i_reset,
  input  logic                             i_rx_done_tick,
  input  logic [NB_DATA-1:0]               i_rx_data,
  input  logic                             i_s_tick,
  input  logic                             i_ready,
  input  logic                             i_clear_overrun,
  output logic                             o_valid,
  output logic [NB_DATA*NB_BYTES-1:0]      o_word,
  output logic [$clog2(NB_BYTES)-1:0]      o_byte_count,
  output logic                             o_overrun,
  output logic                             o_timeout
);

  localparam int unsigned NB_WORD  = NB_DATA * NB_BYTES;
  localparam int unsigned NB_IDX   = $clog2(NB_BYTES);
  localparam int unsigned NB_CNT   = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
  localparam int unsigned CNT_LAST = (TIMEOUT_TICKS > 0) ? TIMEOUT_TICKS - 1 : 0;
  localparam logic [NB_IDX-1:0] IDX_LAST = NB_IDX'(NB_BYTES - 1);

  logic [NB_WORD-1:0] asm_q;
  logic [NB_WORD-1:0] asm_next;
  logic               asm_full;
  logic [NB_IDX-1:0]  idx;
  logic [NB_CNT-1:0]  cnt;

  logic out_free;
  logic last;
  logic accept;
  logic drain;
  logic load_direct;
  logic overrun_set;
  logic expire;

  // Handshake, accept/drain decisions and the assembly word with the incoming byte merged in.
  // While asm_full is set idx is always 0, so a byte arriving with a drain lands in slice 0.
  always_comb begin
    out_free    = ~o_valid | i_ready;
    last        = (idx == IDX_LAST);
    accept      = i_rx_done_tick & (~asm_full | out_free);
    drain       = asm_full & out_free;
    load_direct = accept & last & out_free;
    overrun_set = i_rx_done_tick & asm_full & ~out_free;
    expire      = (TIMEOUT_TICKS != 0) && (idx != '0) && !asm_full && i_s_tick &&
                  (cnt == NB_CNT'(CNT_LAST)) && !accept;
    asm_next    = asm_q;
    for (int unsigned b = 0; b < NB_BYTES; b++) begin
      if (idx == NB_IDX'(b)) asm_next[b*NB_DATA +: NB_DATA] = i_rx_data;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      asm_q     <= '0;
      asm_full  <= 1'b0;
      idx       <= '0;
      cnt       <= '0;
      o_valid   <= 1'b0;
      o_word    <= '0;
      o_overrun <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      if (accept) asm_q <= asm_next;

      if (drain)                        asm_full <= 1'b0;
      else if (accept & last & ~out_free) asm_full <= 1'b1;

      if (accept)      idx <= last ? '0 : idx + NB_IDX'(1);
      else if (expire) idx <= '0;

      // Output register: a new word may load on the same cycle the previous one transfers.
      if (load_direct) begin
        o_word  <= asm_next;
        o_valid <= 1'b1;
      end else if (drain) begin
        o_word  <= asm_q;
        o_valid <= 1'b1;
      end else if (o_valid & i_ready) begin
        o_valid <= 1'b0;
      end

      if ((TIMEOUT_TICKS == 0) || accept || (idx == '0) || expire) cnt <= '0;
      else if (i_s_tick)                                         cnt <= cnt + NB_CNT'(1);

      o_timeout <= expire;

      if (overrun_set)          o_overrun <= 1'b1;
      else if (i_clear_overrun) o_overrun <= 1'b0;
    end
  end

  assign o_byte_count = idx;

endmodule
